// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the picoMIPS program counter.
//   pc_op_t             - PC operation selected by the instruction decoder
//   DEFAULT_ADDR_WIDTH  - default program memory address width
//   DEFAULT_STACK_DEPTH - default return-address stack depth
package pc_pkg;

    typedef enum logic [2:0] {
        PC_INC  = 3'd0,
        PC_JMP  = 3'd1,
        PC_REL  = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_op_t;

    localparam int DEFAULT_ADDR_WIDTH  = 8;
    localparam int DEFAULT_STACK_DEPTH = 4;

endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if: decoder <-> program counter bundle.
//   advance, op, target          - driven by the decoder (master)
//   addr                         - registered program memory address
//   stack_empty, stack_full      - return stack occupancy
//   overflow, underflow          - sticky stack error flags
interface pc_stack_if
    import pc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  advance;
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output advance, op, target,
        input  addr, stack_empty, stack_full, overflow, underflow
    );

    modport slave (
        input  advance, op, target,
        output addr, stack_empty, stack_full, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_return_stack.sv
// return_stack: LIFO of return addresses.
//   clk, reset  - clock, synchronous active-high reset (clears count only)
//   push, din   - push din; ignored when full
//   pop         - drop top entry; ignored when empty (push wins if both)
//   dout        - top entry (entry count-1); undefined when empty
//   full, empty - decoded from the registered count
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign dout    = mem[IW'(count - CW'(1))];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    // Entries carry no reset: slots at or above count are never read.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[IW'(count)] <= din;
        end
    end
endmodule

// File: rtl/pc_stack.sv
// pc_stack: parametrised picoMIPS program counter with return-address stack.
//   clk   - system clock, all state on rising edge
//   reset - synchronous active-high reset, overrides advance/op
//   bus   - pc_stack_if slave: advance/op/target in; addr, stack_empty,
//           stack_full, overflow, underflow out (all registered)
module pc_stack
    import pc_pkg::*;
#(
    parameter int                      ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                      STACK_DEPTH = DEFAULT_STACK_DEPTH,
    parameter logic [ADDR_WIDTH-1:0]   RESET_ADDR  = '0
) (
    input  logic       clk,
    input  logic       reset,
    pc_stack_if.slave  bus
);
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic [ADDR_WIDTH-1:0] stack_top;
    logic                  is_call;
    logic                  is_ret;
    logic                  st_full;
    logic                  st_empty;
    logic                  overflow_q;
    logic                  underflow_q;

    assign pc_plus1 = pc + ADDR_WIDTH'(1);
    assign is_call  = bus.advance && (bus.op == PC_CALL);
    assign is_ret   = bus.advance && (bus.op == PC_RET);

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (is_call),
        .pop   (is_ret),
        .din   (pc_plus1),
        .dout  (stack_top),
        .full  (st_full),
        .empty (st_empty)
    );

    always_comb begin
        pc_next = pc_plus1;
        unique case (bus.op)
            PC_JMP:  pc_next = bus.target;
            PC_REL:  pc_next = pc + bus.target;   // modulo add == signed offset
            PC_CALL: pc_next = bus.target;
            PC_RET:  pc_next = st_empty ? pc_plus1 : stack_top;
            default: pc_next = pc_plus1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_ADDR;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.advance) begin
            pc <= pc_next;
            if (is_call && st_full) begin
                overflow_q <= 1'b1;
            end
            if (is_ret && st_empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign bus.addr        = pc;
    assign bus.stack_empty = st_empty;
    assign bus.stack_full  = st_full;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scenarios plus randomized traffic for pc_stack,
// checked against a queue-based reference model of the PC and return stack.
module tb_pc_stack;
    import pc_pkg::*;

    localparam int   AW    = 8;
    localparam int   DEPTH = 4;
    localparam logic [AW-1:0] RST_ADDR = 8'h00;

    logic clk;
    logic reset;

    pc_stack_if #(.ADDR_WIDTH(AW)) bus ();

    pc_stack #(
        .ADDR_WIDTH  (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (RST_ADDR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_stack [$];
    logic          m_ovf;
    logic          m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic adv, input logic [2:0] op,
                              input logic [AW-1:0] tgt);
        if (rst) begin
            m_pc = RST_ADDR;
            m_stack.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (adv) begin
            case (op)
                3'd1: m_pc = tgt;
                3'd2: m_pc = m_pc + tgt;
                3'd3: begin
                    if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                    else m_stack.push_back(m_pc + 8'd1);
                    m_pc = tgt;
                end
                3'd4: begin
                    if (m_stack.size() == 0) begin
                        m_udf = 1'b1;
                        m_pc  = m_pc + 8'd1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                default: m_pc = m_pc + 8'd1;
            endcase
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic adv,
                        input logic [2:0] op, input logic [AW-1:0] tgt);
        @(negedge clk);
        reset       = rst;
        bus.advance = adv;
        bus.op      = op;
        bus.target  = tgt;
        @(posedge clk);
        model_step(rst, adv, op, tgt);
        #1;
        check({tag, ".addr"},  32'(bus.addr),        32'(m_pc));
        check({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stack.size() == 0));
        check({tag, ".full"},  32'(bus.stack_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".ovf"},   32'(bus.overflow),    32'(m_ovf));
        check({tag, ".udf"},   32'(bus.underflow),   32'(m_udf));
    endtask

    initial begin
        reset       = 1'b1;
        bus.advance = 1'b0;
        bus.op      = 3'd0;
        bus.target  = '0;

        // Reset, increments, stall
        step("rst", 1'b1, 1'b1, PC_CALL, 8'h55);
        check("rst_addr", 32'(bus.addr), 32'h0);
        for (int i = 0; i < 3; i++) step("inc", 1'b0, 1'b1, PC_INC, 8'h00);
        check("inc3_addr", 32'(bus.addr), 32'h3);
        for (int i = 0; i < 2; i++) step("hold", 1'b0, 1'b0, 3'($urandom_range(0, 7)), 8'($urandom));
        check("hold_addr", 32'(bus.addr), 32'h3);

        // Relative branches, including wrap
        step("jmp10", 1'b0, 1'b1, PC_JMP, 8'h10);
        step("relneg", 1'b0, 1'b1, PC_REL, 8'hFC);
        check("relneg_addr", 32'(bus.addr), 32'h0C);
        step("jmpfe", 1'b0, 1'b1, PC_JMP, 8'hFE);
        step("relwrap", 1'b0, 1'b1, PC_REL, 8'h05);
        check("relwrap_addr", 32'(bus.addr), 32'h03);
        step("jmpff", 1'b0, 1'b1, PC_JMP, 8'hFF);
        step("incwrap", 1'b0, 1'b1, PC_INC, 8'h00);

        // Call / return
        step("jmp20", 1'b0, 1'b1, PC_JMP, 8'h20);
        step("call", 1'b0, 1'b1, PC_CALL, 8'h80);
        step("cinc", 1'b0, 1'b1, PC_INC, 8'h00);
        step("ret", 1'b0, 1'b1, PC_RET, 8'h00);
        check("ret_addr", 32'(bus.addr), 32'h21);

        // Return address wrap from all-ones
        step("jmpff2", 1'b0, 1'b1, PC_JMP, 8'hFF);
        step("callff", 1'b0, 1'b1, PC_CALL, 8'h30);
        step("retff", 1'b0, 1'b1, PC_RET, 8'h00);
        check("retwrap_addr", 32'(bus.addr), 32'h00);

        // Nested calls to full, overflow, LIFO unwind
        for (int i = 0; i < DEPTH; i++) step("ncall", 1'b0, 1'b1, PC_CALL, 8'(8'h90 + 8'(i * 16)));
        check("nest_full", 32'(bus.stack_full), 32'h1);
        step("ovcall", 1'b0, 1'b1, PC_CALL, 8'h40);
        check("ov_addr", 32'(bus.addr), 32'h40);
        check("ov_flag", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < DEPTH; i++) step("nret", 1'b0, 1'b1, PC_RET, 8'h00);
        check("nret_empty", 32'(bus.stack_empty), 32'h1);

        // Underflow, sticky across further ops
        step("rst2", 1'b1, 1'b0, PC_INC, 8'h00);
        step("uret", 1'b0, 1'b1, PC_RET, 8'h00);
        check("uret_addr", 32'(bus.addr), 32'h1);
        for (int i = 0; i < 10; i++) step("usticky", 1'b0, 1'(($urandom & 3) != 0), 3'($urandom_range(0, 3)), 8'($urandom));
        check("udf_sticky", 32'(bus.underflow), 32'h1);

        // Mid-operation reset
        step("rst3", 1'b1, 1'b0, PC_INC, 8'h00);
        step("mcall1", 1'b0, 1'b1, PC_CALL, 8'h50);
        step("mcall2", 1'b0, 1'b1, PC_CALL, 8'h60);
        step("mrst", 1'b1, 1'b1, PC_CALL, 8'h70);
        check("mrst_empty", 32'(bus.stack_empty), 32'h1);
        step("mret", 1'b0, 1'b1, PC_RET, 8'h00);
        check("mret_udf", 32'(bus.underflow), 32'h1);

        // Randomized traffic, ops weighted toward call/return
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            int unsigned r;
            r  = $urandom_range(0, 9);
            op = (r < 3) ? PC_CALL : (r < 6) ? PC_RET : 3'($urandom_range(0, 7));
            step("rnd", 1'(($urandom & 63) == 0), 1'(($urandom & 3) != 0), op, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
